// File: rtl/d_ff_pet_syn_rst.sv
// d_ff_pet_syn_rst
//   Positive-edge D register chain with a synchronous active-high reset and a
//   clock enable. Generic state/delay element: WIDTH bits wide and STAGES
//   cascaded registers deep. WIDTH=1, STAGES=1 is a plain D flip-flop.
//
// Parameters
//   WIDTH        data width in bits (>=1)
//   STAGES       number of cascaded stages (>=1); latency in enabled edges
//   RESET_VALUE  value loaded into every stage on reset
//
// Ports
//   clk       in   1      clock, rising edge only
//   reset_in  in   1      synchronous reset, active-high, overrides en_in
//   en_in     in   1      clock enable, active-high
//   d_in      in   WIDTH  data input
//   q_out     out  WIDTH  last stage, straight from a register
//   qn_out    out  WIDTH  ~q_out (present only when D_FF_QN_EN is defined)
//
// Build option
//   D_FF_QN_EN  adds the inverted output qn_out.

module d_ff_pet_syn_rst #(
  parameter int unsigned       WIDTH       = 1,
  parameter int unsigned       STAGES      = 1,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             en_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
`ifdef D_FF_QN_EN
  ,
  output logic [WIDTH-1:0] qn_out
`endif
);

  typedef logic [WIDTH-1:0] word_t;

  word_t stage [STAGES];
  word_t src   [STAGES];

  // Each stage is built in its own generate iteration so every index is an
  // elaboration-time constant; src[] gives stage 0 its feed from d_in and
  // every later stage its feed from the stage before it.
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign src[g] = d_in;
    end else begin : g_link
      assign src[g] = stage[g-1];
    end

    always_ff @(posedge clk) begin
      if (reset_in) begin
        stage[g] <= RESET_VALUE;
      end else if (en_in) begin
        stage[g] <= src[g];
      end
    end
  end

  assign q_out = stage[STAGES-1];

`ifdef D_FF_QN_EN
  assign qn_out = ~q_out;
`endif

endmodule

// File: tb/tb_d_ff_pet_syn_rst.sv
// tb_d_ff_pet_syn_rst
//   Scoreboard bench for d_ff_pet_syn_rst. Three instances share reset/enable:
//     a: WIDTH=1, STAGES=1, RESET_VALUE=0      (plain flip-flop)
//     b: WIDTH=8, STAGES=3, RESET_VALUE=8'h00  (pipeline)
//     c: WIDTH=8, STAGES=2, RESET_VALUE=8'h3C  (non-zero reset value)
//   Each directed vector holds the inputs for one rising edge together with
//   hand-computed outputs after that edge. The stimulus process pushes the
//   expected outputs; the monitor pops and compares on every falling edge.
//   Between edges the inputs are scrambled (including reset_in) so that any
//   level-sensitive or asynchronous behaviour would corrupt the sampled value.

module tb_d_ff_pet_syn_rst;

  logic       clk = 1'b0;
  logic       reset_in;
  logic       en_in;
  logic       d1;
  logic [7:0] d8;
  logic       q_a;
  logic [7:0] q_b;
  logic [7:0] q_c;
`ifdef D_FF_QN_EN
  logic       qn_a;
  logic [7:0] qn_b;
  logic [7:0] qn_c;
`endif

  always #10 clk = ~clk;

  d_ff_pet_syn_rst #(.WIDTH(1), .STAGES(1), .RESET_VALUE(1'b0)) dut_a (
    .clk(clk), .reset_in(reset_in), .en_in(en_in), .d_in(d1), .q_out(q_a)
`ifdef D_FF_QN_EN
    , .qn_out(qn_a)
`endif
  );

  d_ff_pet_syn_rst #(.WIDTH(8), .STAGES(3), .RESET_VALUE(8'h00)) dut_b (
    .clk(clk), .reset_in(reset_in), .en_in(en_in), .d_in(d8), .q_out(q_b)
`ifdef D_FF_QN_EN
    , .qn_out(qn_b)
`endif
  );

  d_ff_pet_syn_rst #(.WIDTH(8), .STAGES(2), .RESET_VALUE(8'h3C)) dut_c (
    .clk(clk), .reset_in(reset_in), .en_in(en_in), .d_in(d8), .q_out(q_c)
`ifdef D_FF_QN_EN
    , .qn_out(qn_c)
`endif
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic       d1;
    logic [7:0] d8;
    logic       qa;
    logic [7:0] qb;
    logic [7:0] qc;
  } vec_t;

  typedef struct {
    int         idx;
    logic       qa;
    logic [7:0] qb;
    logic [7:0] qc;
  } exp_t;

  vec_t vecs [$];
  exp_t sb   [$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input logic rst, input logic en, input logic v1,
                     input logic [7:0] v8, input logic ea,
                     input logic [7:0] eb, input logic [7:0] ec);
    vec_t v;
    v.rst = rst; v.en = en; v.d1 = v1; v.d8 = v8;
    v.qa = ea; v.qb = eb; v.qc = ec;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input int k);
    exp_t e;
    reset_in = vecs[k].rst;
    en_in    = vecs[k].en;
    d1       = vecs[k].d1;
    d8       = vecs[k].d8;
    e.idx = k; e.qa = vecs[k].qa; e.qb = vecs[k].qb; e.qc = vecs[k].qc;
    sb.push_back(e);
  endtask

  // Monitor: one expected entry per rising edge, checked half a cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("q_a", e.idx, {7'b0, q_a}, {7'b0, e.qa});
        check("q_b", e.idx, q_b, e.qb);
        check("q_c", e.idx, q_c, e.qc);
`ifdef D_FF_QN_EN
        check("qn_a", e.idx, {7'b0, qn_a}, {7'b0, ~e.qa});
        check("qn_b", e.idx, qn_b, ~e.qb);
        check("qn_c", e.idx, qn_c, ~e.qc);
`endif
      end
    end
  end

  // Stimulus
  initial begin
    //   rst en d1 d8      qa qb     qc
    add(1, 1, 1, 8'hA5,  0, 8'h00, 8'h3C); // e0 reset wins over data
    add(1, 1, 1, 8'hFF,  0, 8'h00, 8'h3C); // e1 reset held
    add(1, 0, 1, 8'h11,  0, 8'h00, 8'h3C); // e2 reset with en low
    add(0, 1, 1, 8'hA5,  1, 8'h00, 8'h3C); // e3 first post-reset sample
    add(0, 1, 0, 8'h00,  0, 8'h00, 8'hA5); // e4 c latency 2
    add(0, 1, 1, 8'h00,  1, 8'hA5, 8'h00); // e5 b latency 3
    add(0, 0, 0, 8'h77,  1, 8'hA5, 8'h00); // e6 hold
    add(0, 0, 0, 8'h88,  1, 8'hA5, 8'h00); // e7 hold
    add(0, 0, 0, 8'h99,  1, 8'hA5, 8'h00); // e8 hold
    add(0, 1, 1, 8'h5A,  1, 8'h00, 8'h00); // e9
    add(1, 1, 0, 8'hC3,  0, 8'h00, 8'h3C); // e10 reset flushes 5A
    add(0, 1, 1, 8'hA5,  1, 8'h00, 8'h3C); // e11 A5 enters pipe
    add(1, 1, 0, 8'h00,  0, 8'h00, 8'h3C); // e12 reset discards A5
    add(0, 1, 0, 8'h00,  0, 8'h00, 8'h3C); // e13
    add(0, 1, 0, 8'h00,  0, 8'h00, 8'h00); // e14
    add(0, 1, 0, 8'h00,  0, 8'h00, 8'h00); // e15 A5 never appears
    add(0, 1, 0, 8'hF0,  0, 8'h00, 8'h00); // e16
    add(0, 1, 1, 8'h0F,  1, 8'h00, 8'hF0); // e17
    add(0, 1, 1, 8'hC3,  1, 8'hF0, 8'h0F); // e18
    add(0, 1, 0, 8'h00,  0, 8'h0F, 8'hC3); // e19
    add(0, 0, 1, 8'hFF,  0, 8'h0F, 8'hC3); // e20 hold mid-stream
    add(0, 1, 0, 8'h00,  0, 8'hC3, 8'h00); // e21 resume

    #1;
    apply(0);
    for (int k = 1; k < vecs.size(); k++) begin
      @(posedge clk);
      // Scramble between edges: none of this may reach the outputs.
      #2;
      reset_in = ~reset_in;
      en_in    = ~en_in;
      d1       = ~d1;
      d8       = ~d8;
      #3;
      reset_in = ~reset_in;
      d8       = d8 ^ 8'h5A;
      #7;
      apply(k);
    end
    @(posedge clk);
    #15;

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
